sram_seq: RTL and testbench
===========================

# sram_seq

Bus-side sequencer that sits directly upstream of the byte-wide on-chip BSRAM block. It accepts 32-bit word requests from the CPU memory bus (valid/ready with byte write strobes) and serialises each into four byte accesses on the BSRAM's single 8-bit synchronous port. On reads it reassembles the bytes into a little-endian 32-bit word. One instance drives one BSRAM instance; both share `clk_i`.

## Interface
Parameters:
- `WORD_ADDRESS_WIDTH`, default 13: BSRAM byte-address width. It must match the downstream BSRAM instance and be at least 2.

Ports:
- `clk_i` in 1: system clock. All logic is on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: bus request. It is held with `addr_i`, `wstrb_i` and `wdata_i` stable until `ready_o`.
- `addr_i` in `WORD_ADDRESS_WIDTH`: byte address. Bits [1:0] are ignored, so accesses are word-aligned.
- `wstrb_i` in 4: byte write strobes. `4'b0000` means a read.
- `wdata_i` in 32: write data. Lane k is bits [8k+7:8k].
- `rdata_o` out 32: read data. It is valid when `ready_o` is high after a read.
- `ready_o` out 1: one-cycle completion pulse.
- `ram_clk_en_o` out 1: BSRAM port enable.
- `ram_wrt_en_o` out 1: BSRAM write enable.
- `ram_addr_o` out `WORD_ADDRESS_WIDTH`: BSRAM byte address.
- `ram_data_o` out 8: BSRAM write data.
- `ram_data_i` in 8: BSRAM registered read data. It arrives one cycle after the enabled access.

## Operation
States are IDLE, ISSUE, WAIT and DONE, plus a 2-bit lane counter `lane`.
- **IDLE**
  - If `valid_i` is high: latch `base = {addr_i[W-1:2], 2'b00}`, latch `is_wr = |wstrb_i`, latch the strobes and data, set `lane = 0`, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Outputs: `ram_clk_en_o = 1`, `ram_addr_o = base | lane`, `ram_data_o = wdata[8*lane +: 8]`, `ram_wrt_en_o = is_wr & wstrb[lane]`.
  - Lanes with a cleared strobe are still enabled, as a read, so every access has a fixed length.
  - `lane` increments each cycle. When `lane == 3`, go to WAIT.
- **WAIT**
  - `ram_clk_en_o = 0`.
  - Captures the final read byte, then goes to DONE.
- **DONE**
  - `ready_o = 1` for exactly one cycle, then go to IDLE.
  - `valid_i` seen in DONE is ignored. The next request is sampled in IDLE, one cycle after `ready_o`.
- **Read capture**
  - On reads, the byte from lane k is written into `rdata_o[8k+7:8k]` in the cycle after lane k is issued.
  - On writes, `rdata_o` is not modified.
  - `rdata_o` holds its value between reads.
- **Strobes**
  - Any non-zero strobe makes the access a write.
  - Unstrobed lanes leave memory unchanged.
  - Outputs are registered-state decodes: no combinational path from `valid_i` to any `ram_*` output.

## Timing
- Request first seen in IDLE at cycle T. Lanes 0..3 are issued in cycles T+1..T+4. WAIT is T+5. `ready_o` is high in T+6.
- Read latency is 6 cycles from the sampled request to `ready_o`. Throughput is one access per 7 cycles when `valid_i` is re-asserted immediately.
- Reset values:
  - `ready_o = 0`, `ram_clk_en_o = 0`, `ram_wrt_en_o = 0`.
  - `ram_addr_o = 0`, `ram_data_o = 0`, `rdata_o = 0`.
  - State is IDLE and `lane = 0`.
- Reset asserted mid-operation aborts the access immediately and asynchronously.
  - No further BSRAM enables are issued and `ready_o` is not produced.
  - Bytes already written stay written; partial writes are permitted.
- Address wrap: `base | lane` never carries out of the word, so the last word (`base = 2^W - 4`) accesses bytes 2^W-4 .. 2^W-1 only.

## Configuration
- `SRAM_SEQ_FAST_WRITE_EN`
  - Defined: on writes (`is_wr = 1`), ISSUE goes directly to DONE after lane 3, skipping WAIT. `ready_o` is then high in T+5, giving write latency 5. Reads are unchanged at latency 6.
  - Undefined: every access passes through WAIT, so reads and writes both have latency 6.

## Test plan
- **Reset values:** assert `rst_ni = 0` mid-ISSUE at lane 2. Required: `ram_clk_en_o`, `ram_wrt_en_o` and `ready_o` go to 0 at once; `rdata_o = 0`; after release the block returns to IDLE with no `ready_o` pulse.
- **Full-word write then read:** write `addr_i = 0x010`, `wstrb_i = 4'hF`, `wdata_i = 0xDEADBEEF`.
  - Required write: BSRAM bytes 0x010..0x013 = EF, BE, AD, DE, and `ready_o` at T+6 (T+5 with the macro).
  - Required read-back: `rdata_o = 0xDEADBEEF` with `ready_o` at T+6.
- **Partial strobe:** preload 0x11223344, then write `wstrb_i = 4'b0101`, `wdata_i = 0xAABBCCDD`. Required read-back: 0x11BB33DD.
- **Misaligned address:** read with `addr_i = 0x013`. Required: BSRAM addresses 0x010..0x013 issued in order, and the same data as a read at 0x010.
- **Last word and back-to-back:** hold `valid_i` high across two reads at `2^W - 4`. Required: `ram_addr_o` never exceeds 2^W-1, `ready_o` pulses are exactly 7 cycles apart, and `valid_i` in DONE does not start an extra access.

Source files
------------

// File: rtl/sram_seq.sv
// sram_seq: bus-side sequencer that splits each 32-bit word request into four
// byte accesses on a byte-wide synchronous BSRAM port and reassembles read
// bytes little-endian. Optional build macro: SRAM_SEQ_FAST_WRITE_EN (writes
// skip the WAIT state and complete one cycle earlier).
module sram_seq #(
  parameter int WORD_ADDRESS_WIDTH = 13
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  input  logic [WORD_ADDRESS_WIDTH-1:0] addr_i,
  input  logic [3:0]                    wstrb_i,
  input  logic [31:0]                   wdata_i,
  output logic [31:0]                   rdata_o,
  output logic                          ready_o,
  output logic                          ram_clk_en_o,
  output logic                          ram_wrt_en_o,
  output logic [WORD_ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [7:0]                    ram_data_o,
  input  logic [7:0]                    ram_data_i
);

  localparam int W = WORD_ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   lane_q, lane_d;
  logic [W-3:0] word_q, word_d;      // word index: base address without lane bits
  logic         is_wr_q, is_wr_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         cap_vld_q, cap_vld_d;  // ram_data_i carries a read byte this cycle
  logic [1:0]   cap_lane_q, cap_lane_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         ready_q, ready_d;
  logic         ram_en_q, ram_en_d;
  logic         ram_we_q, ram_we_d;
  logic [W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]   ram_data_q, ram_data_d;

  // Pick byte lane from a 32-bit word.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
  endfunction

  // Replace one byte lane of a 32-bit word.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
    lane_merge = word;
    case (lane)
      2'd0:    lane_merge[7:0]   = b;
      2'd1:    lane_merge[15:8]  = b;
      2'd2:    lane_merge[23:16] = b;
      default: lane_merge[31:24] = b;
    endcase
  endfunction

  // Sequencer next state: request latch, lane counter, state transitions.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    is_wr_d = is_wr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          word_d  = addr_i[W-1:2];
          is_wr_d = |wstrb_i;
          wstrb_d = wstrb_i;
          wdata_d = wdata_i;
          lane_d  = 2'd0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
`ifdef SRAM_SEQ_FAST_WRITE_EN
          state_d = is_wr_q ? DONE : WAIT;
`else
          state_d = WAIT;
`endif
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;  // valid_i ignored here; next request sampled in IDLE
      default: state_d = IDLE;
    endcase
  end

  // Registered output decode from the next state, plus read-byte capture.
  always_comb begin
    ram_en_d   = (state_d == ISSUE);
    ram_addr_d = '0;
    ram_data_d = 8'h00;
    ram_we_d   = 1'b0;
    if (ram_en_d) begin
      // Lane bits replace the low address bits, so the address never leaves the word.
      ram_addr_d = {word_d, lane_d};
      ram_data_d = lane_byte(wdata_d, lane_d);
      ram_we_d   = is_wr_d & wstrb_d[lane_d];
    end else begin
      ram_addr_d = '0;
      ram_data_d = 8'h00;
      ram_we_d   = 1'b0;
    end
    ready_d    = (state_d == DONE);
    // BSRAM returns data one cycle after the enabled access.
    cap_vld_d  = (state_q == ISSUE) & ~is_wr_q;
    cap_lane_d = lane_q;
    if (cap_vld_q) begin
      rdata_d = lane_merge(rdata_q, cap_lane_q, ram_data_i);
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      word_q     <= '0;
      is_wr_q    <= 1'b0;
      wstrb_q    <= 4'h0;
      wdata_q    <= 32'h0000_0000;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= 2'd0;
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      is_wr_q    <= is_wr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign ready_o      = ready_q;
  assign ram_clk_en_o = ram_en_q;
  assign ram_wrt_en_o = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_data_o   = ram_data_q;

endmodule

// File: tb/tb_sram_seq.sv
// Directed bench for sram_seq with a behavioural byte-wide BSRAM model.
module tb_sram_seq;

  localparam int W = 13;
`ifdef SRAM_SEQ_FAST_WRITE_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 6;
`endif
  localparam int RD_LAT = 6;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic [W-1:0] addr_i;
  logic [3:0]   wstrb_i;
  logic [31:0]  wdata_i;
  logic [31:0]  rdata_o;
  logic         ready_o;
  logic         ram_clk_en_o;
  logic         ram_wrt_en_o;
  logic [W-1:0] ram_addr_o;
  logic [7:0]   ram_data_o;
  logic [7:0]   ram_data_i;

  int total = 0;
  int bad   = 0;

  logic [7:0]   mem [0:(1<<W)-1];
  logic [W-1:0] addr_log [$];

  sram_seq #(.WORD_ADDRESS_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .addr_i(addr_i),
    .wstrb_i(wstrb_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ready_o(ready_o),
    .ram_clk_en_o(ram_clk_en_o), .ram_wrt_en_o(ram_wrt_en_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  // BSRAM model: synchronous port, registered read-first data.
  always @(posedge clk_i) begin
    if (ram_clk_en_o) begin
      ram_data_i <= mem[ram_addr_o];
      if (ram_wrt_en_o) mem[ram_addr_o] <= ram_data_o;
      addr_log.push_back(ram_addr_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a falling edge; lat = cycles until ready_o (0 = timeout).
  task automatic access(input logic [W-1:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int lat);
    valid_i = 1'b1; addr_i = a; wstrb_i = s; wdata_i = d; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    valid_i = 1'b0; wstrb_i = 4'h0;
    @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < (1<<W); i++) mem[i] = 8'h00;
    ram_data_i = 8'h00;
  end

  initial begin
    int lat;
    int seen;
    int r1, r2, cyc, npulse;
    logic [W-1:0] amax;

    rst_ni = 1'b0; valid_i = 1'b0; addr_i = '0; wstrb_i = 4'h0; wdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst_en",    {31'd0, ram_clk_en_o}, 32'd0);
    chk("rst_we",    {31'd0, ram_wrt_en_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o},      32'd0);
    chk("rst_addr",  {19'd0, ram_addr_o},   32'd0);
    chk("rst_data",  {24'd0, ram_data_o},   32'd0);
    chk("rst_rdata", rdata_o,               32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Reset in the middle of a write, while lane 2 is being issued.
    valid_i = 1'b1; addr_i = 13'h020; wstrb_i = 4'hF; wdata_i = 32'h4433_2211;
    @(negedge clk_i);
    chk("abort_l0_en",   {31'd0, ram_clk_en_o}, 32'd1);
    chk("abort_l0_we",   {31'd0, ram_wrt_en_o}, 32'd1);
    chk("abort_l0_addr", {19'd0, ram_addr_o},   32'h020);
    chk("abort_l0_data", {24'd0, ram_data_o},   32'h11);
    valid_i = 1'b0; wstrb_i = 4'h0;
    repeat (2) @(negedge clk_i);
    chk("abort_l2_addr", {19'd0, ram_addr_o}, 32'h022);
    #1 rst_ni = 1'b0;
    #1;
    chk("abort_en",    {31'd0, ram_clk_en_o}, 32'd0);
    chk("abort_we",    {31'd0, ram_wrt_en_o}, 32'd0);
    chk("abort_ready", {31'd0, ready_o},      32'd0);
    chk("abort_rdata", rdata_o,               32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (ready_o !== 1'b0 || ram_clk_en_o !== 1'b0) seen++;
    end
    chk("abort_quiet", seen, 32'd0);
    chk("abort_partial", {8'h00, mem[13'h022], mem[13'h021], mem[13'h020]}, 32'h0000_2211);

    // Full-word write, then read back.
    access(13'h010, 4'hF, 32'hDEAD_BEEF, lat);
    chk("wr_lat", lat, WR_LAT);
    chk("wr_mem", {mem[13'h013], mem[13'h012], mem[13'h011], mem[13'h010]}, 32'hDEAD_BEEF);
    chk("wr_rdata_kept", rdata_o, 32'd0);
    access(13'h010, 4'h0, 32'h0, lat);
    chk("rd_lat", lat, RD_LAT);
    chk("rd_data", rdata_o, 32'hDEAD_BEEF);

    // Partial strobe write over a preloaded word.
    access(13'h040, 4'hF, 32'h1122_3344, lat);
    chk("pre_lat", lat, WR_LAT);
    access(13'h040, 4'b0101, 32'hAABB_CCDD, lat);
    chk("part_lat", lat, WR_LAT);
    chk("part_rdata_hold", rdata_o, 32'hDEAD_BEEF);
    access(13'h040, 4'h0, 32'h0, lat);
    chk("part_data", rdata_o, 32'h11BB_33DD);

    // Misaligned address reads the enclosing word in lane order.
    addr_log.delete();
    access(13'h013, 4'h0, 32'h0, lat);
    chk("mis_data", rdata_o, 32'hDEAD_BEEF);
    chk("mis_count", addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("mis_addr", {19'd0, addr_log[i]}, 32'h010 + i);

    // Last word, then two back-to-back reads with valid_i held high.
    access(13'h1FFC, 4'hF, 32'h5566_7788, lat);
    chk("last_wr_lat", lat, WR_LAT);
    chk("last_mem", {mem[13'h1FFF], mem[13'h1FFE], mem[13'h1FFD], mem[13'h1FFC]}, 32'h5566_7788);
    addr_log.delete();
    valid_i = 1'b1; addr_i = 13'h1FFC; wstrb_i = 4'h0; wdata_i = 32'h0;
    r1 = 0; r2 = 0; npulse = 0; cyc = 0;
    while (npulse < 2 && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (ready_o === 1'b1) begin
        npulse++;
        if (npulse == 1) r1 = cyc; else r2 = cyc;
      end
    end
    valid_i = 1'b0;
    chk("b2b_first", r1, RD_LAT);
    chk("b2b_gap", r2 - r1, 32'd7);
    chk("b2b_data", rdata_o, 32'h5566_7788);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (ready_o !== 1'b0) seen++;
    end
    chk("b2b_no_extra", seen, 32'd0);
    chk("b2b_count", addr_log.size(), 32'd8);
    amax = '0;
    seen = 0;
    foreach (addr_log[i]) begin
      if (addr_log[i] > amax) amax = addr_log[i];
      if (addr_log[i] < 13'h1FFC) seen++;
    end
    chk("b2b_addr_max", {19'd0, amax}, 32'h1FFF);
    chk("b2b_addr_low", seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
